seq_stream_arbiter: RTL

Round-robin controller that time-shares one Moore serial sequence detector (`din`/`dout`, synchronous active-high `reset`) among `N_REQ` serial requesters. It grants the detector lane one fixed-length frame at a time and flushes the detector before every frame so no pattern straddles two owners. It attributes each detector hit to the owning requester and keeps per-requester saturating hit counts. It sits between the serial sources and the single shared detector instance.

---
 rtl/seq_stream_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_stream_arbiter.sv
// Round-robin time-share of one serial sequence detector: FLUSH, FRAME_LEN-bit STREAM, DRAIN per grant.
// Hits reach `hit` two cycles after the completing bit; define SEQ_ARB_CNT_CLR_EN to add the cnt_clr input.
module seq_stream_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef SEQ_ARB_CNT_CLR_EN
  input  logic                   cnt_clr,
`endif
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       din_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic                   det_din,
  output logic                   det_reset,
  input  logic                   det_dout,
  output logic [N_REQ-1:0]       hit,
  output logic [N_REQ*CNT_W-1:0] hit_cnt,
  output logic                   busy
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DRAIN} state_t;

  state_t           state, state_d;
  logic [OW-1:0]    owner, rr_sel;
  logic             arb;
  logic [BW-1:0]    bit_cnt;
  logic             hit_ev;
  logic             clr;
  logic [CNT_W-1:0] cnt_q [N_REQ];

`ifdef SEQ_ARB_CNT_CLR_EN
  assign clr = cnt_clr;
`else
  assign clr = 1'b0;
`endif

  // Scan the wrapped order backwards so the first requester after owner is written last and wins.
  always_comb begin
    rr_sel = owner;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(owner) + i) % N_REQ]) begin
        rr_sel = OW'((int'(owner) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d = state;
    arb     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d = FLUSH;
          arb     = 1'b1;
        end
      end
      FLUSH:  state_d = STREAM;
      STREAM: begin
        if (bit_cnt == BW'(FRAME_LEN - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (|req) begin
          state_d = FLUSH;
          arb     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    det_din = 1'b0;
    if (state == STREAM) begin
      gnt[owner] = 1'b1;
      det_din    = din_bus[owner];
    end
  end

  assign det_reset = reset | (state == FLUSH);
  assign busy      = (state != IDLE);
  // DRAIN is included so the Moore output for the frame's last bit is still attributed.
  assign hit_ev    = det_dout & ((state == STREAM) | (state == DRAIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OW'(N_REQ - 1);
      bit_cnt <= '0;
      hit     <= '0;
    end else begin
      state <= state_d;
      if (arb) owner <= rr_sel;
      if (state == FLUSH) begin
        bit_cnt <= '0;
      end else if (state == STREAM) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      hit <= '0;
      if (hit_ev) hit[owner] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_REQ; k++) begin
      if (reset || clr) begin
        cnt_q[k] <= '0;
      end else if (hit_ev && (owner == OW'(k)) && (cnt_q[k] != CNT_MAX)) begin
        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
